// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // Fetch addresses are always word aligned; the low two bits are discarded.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: reset vector, redirect target, sequential pc+4, or hold.
module pc_next_sel
  import fetch_pkg::*;
(
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_reset_pc,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_rsp_take,
  output logic [XLEN-1:0] o_next_pc
);

  always_comb begin
    o_next_pc = i_pc;
    if (i_rst) begin
      o_next_pc = i_reset_pc;
    end else if (i_redirect_valid) begin
      o_next_pc = align_word(i_redirect_pc);
    end else if (i_rsp_take) begin
      o_next_pc = i_pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and fills the IF/ID slot.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ifid_valid,
  input  logic        ifid_ready,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            r_ifid_valid;
  logic [XLEN-1:0] r_ifid_pc;
  logic [XLEN-1:0] r_ifid_pc_plus4;
  logic [XLEN-1:0] r_ifid_instr;
  logic            w_req_valid;
  logic            w_handshake;
  logic            w_rsp_take;

  // A request may only go out when the slot will be free by the time the word returns.
  assign w_req_valid = (r_state == S_REQ) && (!r_ifid_valid || ifid_ready) && !rst;
  assign w_handshake = w_req_valid && imem_req_ready;
  assign w_rsp_take  = (r_state == S_WAIT) && imem_rsp_valid;

  pc_next_sel u_pc_next_sel (
    .i_rst            (rst),
    .i_reset_pc       (RESET_PC),
    .i_pc             (r_pc),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_rsp_take       (w_rsp_take),
    .o_next_pc        (w_pc_next)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_REQ:   if (w_handshake) w_state_next = redirect_valid ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid)      w_state_next = S_REQ;
        else if (redirect_valid) w_state_next = S_DROP;
      end
      S_DROP:  if (imem_rsp_valid) w_state_next = S_REQ;
      default: w_state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Redirect flushes the slot even when a response lands in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_valid    <= 1'b0;
      r_ifid_pc       <= '0;
      r_ifid_pc_plus4 <= '0;
      r_ifid_instr    <= NOP_INSTR;
    end else if (redirect_valid) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= NOP_INSTR;
    end else if (w_rsp_take) begin
      r_ifid_valid    <= 1'b1;
      r_ifid_pc       <= r_pc;
      r_ifid_pc_plus4 <= r_pc + XLEN'(4);
      r_ifid_instr    <= imem_rsp_data;
    end else if (ifid_ready) begin
      r_ifid_valid <= 1'b0;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign ifid_valid     = r_ifid_valid;
  assign ifid_pc        = r_ifid_pc;
  assign ifid_pc_plus4  = r_ifid_pc_plus4;
  assign ifid_instr     = r_ifid_instr;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed cycle-by-cycle vectors for pc_fetch_stage plus a wrap-around sequence on a second instance.
module tb_pc_fetch_stage;

  typedef struct {
    logic        rst;
    logic        redirValid;
    logic [31:0] redirPc;
    logic        reqReady;
    logic        rspValid;
    logic [31:0] rspData;
    logic        ifidReady;
    logic        expReqValid;
    logic [31:0] expReqAddr;
    logic        expIfidValid;
    logic [31:0] expIfidPc;
    logic [31:0] expIfidPc4;
    logic [31:0] expIfidInstr;
  } vec_t;

  localparam int NUM_VECS = 26;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] D0 = 32'h1111_1111, D1 = 32'h2222_2222, D2 = 32'h3333_3333,
                          D3 = 32'h4444_4444, D4 = 32'h5555_5555, D5 = 32'h5A5A_5A5A,
                          D6 = 32'h6666_6666, DW = 32'h7777_7777;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirectValid, reqReady, rspValid, ifidReady;
  logic [31:0] redirectPc, rspData;
  logic        reqValid, ifidValid;
  logic [31:0] reqAddr, ifidPc, ifidPc4, ifidInstr;

  logic        rst2, rspValid2;
  logic [31:0] rspData2;
  logic        reqValid2, ifidValid2;
  logic [31:0] reqAddr2, ifidPc2, ifidPc42, ifidInstr2;

  int vectorCount = 0;
  int checkCount  = 0;
  int missCount   = 0;
  vec_t vecs [NUM_VECS];

  pc_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirectValid), .redirect_pc(redirectPc),
    .imem_req_valid(reqValid), .imem_req_ready(reqReady), .imem_req_addr(reqAddr),
    .imem_rsp_valid(rspValid), .imem_rsp_data(rspData),
    .ifid_valid(ifidValid), .ifid_ready(ifidReady),
    .ifid_pc(ifidPc), .ifid_pc_plus4(ifidPc4), .ifid_instr(ifidInstr)
  );

  pc_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dutWrap (
    .clk(clk), .rst(rst2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(reqValid2), .imem_req_ready(1'b1), .imem_req_addr(reqAddr2),
    .imem_rsp_valid(rspValid2), .imem_rsp_data(rspData2),
    .ifid_valid(ifidValid2), .ifid_ready(1'b1),
    .ifid_pc(ifidPc2), .ifid_pc_plus4(ifidPc42), .ifid_instr(ifidInstr2)
  );

  task automatic applyStimulus(input vec_t v);
    rst           = v.rst;
    redirectValid = v.redirValid;
    redirectPc    = v.redirPc;
    reqReady      = v.reqReady;
    rspValid      = v.rspValid;
    rspData       = v.rspData;
    ifidReady     = v.ifidReady;
    vectorCount++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  initial begin
    // rst rv rpc rdy rspV rspD ifR | eRV eAddr eIV ePc ePc4 eInstr
    vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   NOP};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,   NOP};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, D0,    1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   NOP};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4,   1'b1, 32'h0,   32'h4,   D0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, D1,    1'b1, 1'b0, 32'h4,   1'b0, 32'h0,   32'h4,   D0};
    for (int i = 5; i < 10; i++)
      vecs[i] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8,   1'b1, 32'h4,   32'h8,   D1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8,   1'b1, 32'h4,   32'h8,   D1};
    vecs[11] = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8,   1'b0, 32'h4,   32'h8,   D1};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, D2,    1'b1, 1'b0, 32'h100, 1'b0, 32'h4,   32'h8,   NOP};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h4,   32'h8,   NOP};
    vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, D3,    1'b1, 1'b0, 32'h100, 1'b0, 32'h4,   32'h8,   NOP};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 1'b1, 32'h100, 32'h104, D3};
    vecs[16] = '{1'b0, 1'b1, 32'h203, 1'b1, 1'b1, D4,    1'b1, 1'b0, 32'h104, 1'b0, 32'h100, 32'h104, D3};
    for (int i = 17; i < 20; i++)
      vecs[i] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h100, 32'h104, NOP};
    vecs[20] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h100, 32'h104, NOP};
    vecs[21] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h100, 32'h104, NOP};
    vecs[22] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, D5,    1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,   NOP};
    vecs[23] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   NOP};
    vecs[24] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, D6,    1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   NOP};
    vecs[25] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4,   1'b1, 32'h0,   32'h4,   D6};

    applyStimulus(vecs[0]);
    vectorCount = 0;
    rst2      = 1'b1;
    rspValid2 = 1'b0;
    rspData2  = 32'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NUM_VECS; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("v%0d req_valid", i), {31'b0, reqValid},  {31'b0, vecs[i].expReqValid});
      checkOutput($sformatf("v%0d req_addr", i),  reqAddr,            vecs[i].expReqAddr);
      checkOutput($sformatf("v%0d ifid_valid", i), {31'b0, ifidValid}, {31'b0, vecs[i].expIfidValid});
      checkOutput($sformatf("v%0d ifid_pc", i),   ifidPc,             vecs[i].expIfidPc);
      checkOutput($sformatf("v%0d ifid_pc4", i),  ifidPc4,            vecs[i].expIfidPc4);
      checkOutput($sformatf("v%0d ifid_instr", i), ifidInstr,         vecs[i].expIfidInstr);
    end

    // Wrap-around: the instance resetting to 0xFFFF_FFFC must roll over to 0.
    @(negedge clk);
    rst2 = 1'b0;
    vectorCount++;
    #2;
    checkOutput("wrap req_valid", {31'b0, reqValid2}, 32'h1);
    checkOutput("wrap req_addr",  reqAddr2,           32'hFFFF_FFFC);
    @(negedge clk);
    rspValid2 = 1'b1;
    rspData2  = DW;
    vectorCount++;
    #2;
    checkOutput("wrap wait req_valid", {31'b0, reqValid2}, 32'h0);
    @(negedge clk);
    rspValid2 = 1'b0;
    vectorCount++;
    #2;
    checkOutput("wrap ifid_valid", {31'b0, ifidValid2}, 32'h1);
    checkOutput("wrap ifid_pc",    ifidPc2,             32'hFFFF_FFFC);
    checkOutput("wrap ifid_pc4",   ifidPc42,            32'h0);
    checkOutput("wrap ifid_instr", ifidInstr2,          DW);
    checkOutput("wrap next addr",  reqAddr2,            32'h0);
    checkOutput("wrap next valid", {31'b0, reqValid2},  32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
